// File: rtl/usb_ep_rr_arbiter.sv
// usb_ep_rr_arbiter: round-robin arbiter that multiplexes per-endpoint byte streams
// onto a single shared packet buffer, with hold timeout and forced revocation.
module usb_ep_rr_arbiter #(
    parameter int NUM_EPS = 4,
    parameter int TIMEOUT = 3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_EPS-1:0]   ep_req,
    output logic [NUM_EPS-1:0]   ep_grant,
    input  logic [NUM_EPS-1:0]   ep_put,
    input  logic [8*NUM_EPS-1:0] ep_data,
    input  logic [NUM_EPS-1:0]   ep_done,
    output logic [NUM_EPS-1:0]   ep_free,
    output logic                 buf_put,
    output logic [7:0]           buf_data,
    output logic                 buf_done,
    input  logic                 buf_full,
    output logic [2:0]           active_ep,
    output logic                 busy,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state;
    logic [2:0]         ptr, win, ptr_nxt;
    logic [3:0]         idx;
    logic [11:0]        hold, hold_inc;
    logic [7:0]         req_p, put_p, done_p;
    logic [63:0]        data_p;
    logic [NUM_EPS-1:0] grant_nxt;
    logic               any, in_grant, req_w, done_w, fin, tmo;

    // Widen the endpoint vectors to 8 lanes so a 3-bit index is always in range.
    assign req_p  = 8'(ep_req);
    assign put_p  = 8'(ep_put);
    assign done_p = 8'(ep_done);
    assign data_p = 64'(ep_data);

    assign in_grant = state == GRANT;
    assign busy     = state != IDLE;
    assign req_w    = req_p[active_ep];
    assign done_w   = done_p[active_ep];
    assign fin      = done_w || !req_w;
    assign hold_inc = &hold ? hold : hold + 12'd1;
    assign tmo      = (TIMEOUT != 0) && (hold_inc == 12'(TIMEOUT));
    assign ptr_nxt  = (active_ep == 3'(NUM_EPS - 1)) ? 3'd0 : active_ep + 3'd1;

    assign buf_put  = in_grant && put_p[active_ep] && !buf_full;
    assign buf_done = in_grant && done_w;
    assign buf_data = in_grant ? data_p[{active_ep, 3'b000} +: 8] : 8'h00;

    // Scan from the highest offset down so the requester nearest ptr wins last.
    always_comb begin
        idx = '0;
        win = '0;
        any = 1'b0;
        for (int i = NUM_EPS - 1; i >= 0; i--) begin
            idx = 4'(ptr) + 4'(i);
            if (idx >= 4'(NUM_EPS)) idx = idx - 4'(NUM_EPS);
            if (req_p[idx[2:0]]) begin
                win = idx[2:0];
                any = 1'b1;
            end
        end
    end

    always_comb begin
        grant_nxt = '0;
        ep_free   = '0;
        for (int i = 0; i < NUM_EPS; i++) begin
            grant_nxt[i] = win == 3'(i);
            ep_free[i]   = in_grant && !buf_full && (active_ep == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            hold        <= '0;
            ep_grant    <= '0;
            active_ep   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    state     <= GRANT;
                    ep_grant  <= grant_nxt;
                    active_ep <= win;
                    hold      <= '0;
                end
                GRANT: begin
                    hold <= hold_inc;
                    // A done or dropped request in the timeout cycle is a normal exit.
                    if (fin || tmo) begin
                        state       <= RELEASE;
                        ep_grant    <= '0;
                        active_ep   <= '0;
                        ptr         <= ptr_nxt;
                        timeout_err <= !fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_ep_rr_arbiter.sv
// tb_usb_ep_rr_arbiter: directed scenarios plus randomized endpoint traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_usb_ep_rr_arbiter;
    localparam int N   = 4;
    localparam int TMO = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   ep_req = '0, ep_put = '0, ep_done = '0;
    logic [8*N-1:0] ep_data = '0;
    logic           buf_full = 1'b0;
    logic [N-1:0]   ep_grant, ep_free;
    logic           buf_put, buf_done, busy, timeout_err;
    logic [7:0]     buf_data;
    logic [2:0]     active_ep;

    int checks = 0, errors = 0;

    // Model: who owns the buffer, how long, where the rotation resumes.
    int m_owner = -1, m_held = 0, m_ptr = 0;
    bit m_rel = 1'b0, m_err = 1'b0;
    int waits [N];

    always #5 clk = ~clk;

    usb_ep_rr_arbiter #(.NUM_EPS(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .ep_req(ep_req), .ep_grant(ep_grant),
        .ep_put(ep_put), .ep_data(ep_data), .ep_done(ep_done), .ep_free(ep_free),
        .buf_put(buf_put), .buf_data(buf_data), .buf_done(buf_done), .buf_full(buf_full),
        .active_ep(active_ep), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string nm);
        int c = 0;
        while (ep_grant == '0 && c < 8) begin
            step();
            c++;
        end
        chk(nm, 32'(ep_grant != '0), 1);
    endtask

    always @(negedge clk) begin : cmp
        int o, c;
        bit fin;
        logic [N-1:0] eg, ef;
        if (reset) begin
            chk("rst_grant", 32'(ep_grant), 0);
            chk("rst_active", 32'(active_ep), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_terr", 32'(timeout_err), 0);
            chk("rst_buf_put", 32'(buf_put), 0);
            chk("rst_buf_done", 32'(buf_done), 0);
            chk("rst_free", 32'(ep_free), 0);
            chk("rst_buf_data", 32'(buf_data), 0);
            m_owner = -1; m_rel = 1'b0; m_err = 1'b0; m_ptr = 0; m_held = 0;
            for (int k = 0; k < N; k++) waits[k] = 0;
        end else begin
            o = m_owner;
            eg = '0;
            ef = '0;
            if (o >= 0) begin
                eg[o] = 1'b1;
                ef[o] = !buf_full;
            end
            chk("grant", 32'(ep_grant), 32'(eg));
            chk("active_ep", 32'(active_ep), (o >= 0) ? o : 0);
            chk("busy", 32'(busy), 32'(o >= 0 || m_rel));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            chk("ep_free", 32'(ep_free), 32'(ef));
            chk("buf_put", 32'(buf_put), 32'(o >= 0 && ep_put[o] && !buf_full));
            chk("buf_done", 32'(buf_done), 32'(o >= 0 && ep_done[o]));
            chk("buf_data", 32'(buf_data), (o >= 0) ? 32'(ep_data[8*o +: 8]) : 0);
            // Advance to what the next clock edge must produce.
            m_err = 1'b0;
            for (int k = 0; k < N; k++) if (!ep_req[k]) waits[k] = 0;
            if (o >= 0) begin
                m_held++;
                fin = ep_done[o] || !ep_req[o];
                if (fin || m_held == TMO) begin
                    m_err = !fin;
                    m_ptr = (o + 1) % N;
                    m_owner = -1;
                    m_rel = 1'b1;
                end
            end else if (m_rel) begin
                m_rel = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (m_owner < 0 && ep_req[c]) begin
                        m_owner = c;
                        m_held = 0;
                    end
                end
                if (m_owner >= 0) begin
                    for (int j = 0; j < N; j++) begin
                        if (j != m_owner && ep_req[j]) begin
                            waits[j]++;
                            chk("starvation_bound", 32'(waits[j] <= N - 1), 1);
                        end
                    end
                    waits[m_owner] = 0;
                end
            end
        end
    end

    initial begin
        int cnt;
        logic [7:0] got [$];
        logic [39:0] d2;
        logic [4:0] p2;
        logic [31:0] exp3;
        bit last_done [N];
        d2 = 40'h11_00_22_33_00;
        p2 = 5'b10110;
        exp3 = 32'h00_11_22_33;

        ep_req = 4'b0110;
        #2 chk("rst_busy_direct", 32'(busy), 0);
        step();
        reset = 1'b0;
        step();
        chk("042_first_grant", 32'(ep_grant), 4'b0010);
        chk("042_active", 32'(active_ep), 1);
        ep_done = 4'b0010;
        #1 chk("042_buf_done", 32'(buf_done), 1);
        step();
        ep_done = '0;
        chk("042_release_grant", 32'(ep_grant), 0);
        chk("042_release_busy", 32'(busy), 1);
        step();
        chk("042_idle_busy", 32'(busy), 0);
        step();
        chk("042_second_grant", 32'(ep_grant), 4'b0100);
        ep_req = 4'b0100;

        for (int k = 0; k < 5; k++) begin
            step();
            ep_put  = {1'b0, p2[4-k], 1'b0, 1'b1};
            ep_data = {8'h00, d2[8*(4-k) +: 8], 8'h00, 8'hFF};
            #1 if (buf_put) got.push_back(buf_data);
        end
        chk("044_count", 32'(got.size()), 3);
        for (int k = 0; k < 3; k++)
            chk("044_byte", (k < got.size()) ? 32'(got[k]) : 32'hDEAD, 32'(exp3[8*(2-k) +: 8]));
        step();
        ep_put = '0;
        ep_data = '0;
        ep_done = 4'b0100;
        step();
        ep_done = '0;
        ep_req = 4'b1000;
        step(2);
        chk("045_grant", 32'(ep_grant), 4'b1000);
        for (int k = 0; k < 5; k++) begin
            step();
            buf_full = 1'b1;
            ep_put = 4'b1000;
            #1;
            chk("045_free_low", 32'(ep_free), 0);
            chk("045_put_dropped", 32'(buf_put), 0);
            chk("045_grant_held", 32'(ep_grant), 4'b1000);
        end
        step();
        buf_full = 1'b0;
        #1;
        chk("045_free_back", 32'(ep_free), 4'b1000);
        chk("045_put_back", 32'(buf_put), 1);
        step();
        ep_put = '0;
        ep_done = 4'b1000;
        step();
        ep_done = '0;

        wait_grant("046_grant_seen");
        chk("046_grant_ep3", 32'(ep_grant), 4'b1000);
        ep_req = 4'b1001;
        cnt = 0;
        while (ep_grant == 4'b1000 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("046_hold_cycles", 32'(cnt), TMO);
        chk("046_terr_pulse", 32'(timeout_err), 1);
        step();
        chk("046_terr_clear", 32'(timeout_err), 0);
        step();
        chk("046_next_ep0", 32'(ep_grant), 4'b0001);

        step(9);
        ep_done = 4'b0001;
        step();
        chk("028_no_terr", 32'(timeout_err), 0);
        chk("028_released", 32'(ep_grant), 0);
        ep_done = '0;
        ep_req = 4'b0001;

        wait_grant("047_grant_seen");
        chk("047_pre", 32'(ep_grant), 4'b0001);
        step();
        ep_done = 4'b0001;
        #2 reset = 1'b1;
        #1;
        chk("047_async_grant", 32'(ep_grant), 0);
        chk("047_no_done", 32'(buf_done), 0);
        chk("047_busy", 32'(busy), 0);
        ep_done = '0;
        ep_req = 4'b1001;
        step();
        reset = 1'b0;
        step();
        chk("047_after", 32'(ep_grant), 4'b0001);

        for (int k = 0; k < N; k++) last_done[k] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (reset) reset = ($urandom_range(0, 1) == 0);
            else reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (!ep_req[i]) ep_req[i] = ($urandom_range(0, 2) == 0);
                else if (last_done[i] || $urandom_range(0, 39) == 0) ep_req[i] = $urandom_range(0, 1) == 1;
                ep_put[i] = $urandom_range(0, 1) == 1;
                ep_data[8*i +: 8] = 8'($urandom_range(0, 255));
                ep_done[i] = ep_grant[i] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
                last_done[i] = ep_done[i] && ep_grant[i];
            end
            buf_full = ($urandom_range(0, 3) == 0);
        end
        reset = 1'b0;
        ep_req = '0;
        ep_put = '0;
        ep_done = '0;
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
